// File: rtl/sifh_zoom_ctrl.sv
// Coarse-to-fine zoom controller for a TDC histogrammer: each pass narrows the
// time window around the previous peak until the bin width reaches one TDC code.
module sifh_zoom_ctrl #(
   parameter int NP = 16,
   parameter int NB = 4,
   parameter int ZS = 4,
   parameter int SW = $clog2(NP + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [NP-1:0] win_base,
   output logic [NP-1:0] win_hi,
   output logic [SW-1:0] win_shift,
   input  logic          peak_valid,
   input  logic [NB-1:0] peak_bin,
   input  logic          peak_none,
   output logic          busy,
   output logic          res_valid,
   output logic [NP-1:0] res_tof,
   output logic          res_err,
   output logic [SW-1:0] res_passes
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CALC, DONE} state_t;

   state_t              state, state_nx;
   logic [NP-1:0]       base;
   logic [SW-1:0]       shift;
   logic [SW-1:0]       passes;
   logic [NB-1:0]       pk_bin;
   logic                pk_none;

   logic [NP:0]         span;
   logic [NP:0]         hi_full;
   logic [SW-1:0]       s_nx;
   logic [NP+1:0]       half_bin;
   logic signed [NP+1:0] center;
   logic signed [NP+1:0] half_nx;
   logic signed [NP+1:0] b_raw;

   // Slide a window of 2^(s+NB) codes so it lies entirely inside 0..2^NP-1.
   function automatic logic [NP-1:0] clamp_base(input logic signed [NP+1:0] b,
                                                input logic [SW-1:0]        s);
      logic signed [NP+1:0] maxb;
      maxb = signed'(((NP+2)'(1) << NP) - ((NP+2)'(1) << (s + NB)));
      if (b < 0)
         return '0;
      else if (b > maxb)
         return NP'(maxb);
      else
         return NP'(b);
   endfunction

   assign span    = (NP+1)'(1) << (shift + NB);
   assign hi_full = {1'b0, base} + span - (NP+1)'(1);

   // Next window is centred on the middle of the peak bin, ZS octaves finer.
   always_comb begin
      s_nx     = (shift > SW'(ZS)) ? shift - SW'(ZS) : '0;
      half_bin = (shift == '0) ? '0 : ((NP+2)'(1) << (shift - SW'(1)));
      center   = signed'({2'b00, base} + ({{(NP+2-NB){1'b0}}, pk_bin} << shift) + half_bin);
      half_nx  = signed'((NP+2)'(1) << (s_nx + NB - 1));
      b_raw    = center - half_nx;
   end

   always_comb begin
      state_nx  = state;
      win_valid = 1'b0;
      win_base  = '0;
      win_hi    = '0;
      win_shift = '0;
      busy      = (state != IDLE);
      res_valid = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = ISSUE;
         ISSUE: begin
            win_valid = 1'b1;
            win_base  = base;
            win_hi    = hi_full[NP-1:0];
            win_shift = shift;
            if (win_ready) state_nx = WAIT;
         end
         WAIT:  if (peak_valid) state_nx = CALC;
         CALC:  state_nx = (pk_none || shift == '0) ? DONE : ISSUE;
         DONE: begin
            res_valid = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         base       <= '0;
         shift      <= '0;
         passes     <= '0;
         pk_bin     <= '0;
         pk_none    <= 1'b0;
         res_tof    <= '0;
         res_err    <= 1'b0;
         res_passes <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               base   <= '0;
               shift  <= SW'(NP - NB);
               passes <= '0;
            end
            ISSUE: if (win_ready) passes <= passes + SW'(1);
            WAIT: if (peak_valid) begin
               pk_bin  <= peak_bin;
               pk_none <= peak_none;
            end
            CALC: begin
               if (pk_none) begin
                  res_tof    <= '0;
                  res_err    <= 1'b1;
                  res_passes <= passes;
               end else if (shift == '0) begin
                  res_tof    <= base + NP'(pk_bin);
                  res_err    <= 1'b0;
                  res_passes <= passes;
               end else begin
                  base  <= clamp_base(b_raw, s_nx);
                  shift <= s_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sifh_zoom_ctrl.md
SIFH_ZOOM_CTRL -- requirements
Module: sifh_zoom_ctrl

Interface
REQ-001 Parameter NP, default 16: TDC code width in bits; full time range 0..2^NP-1.
REQ-002 Parameter NB, default 4: histogram bin-address width; 2^NB bins per pass.
REQ-003 Parameter ZS, default 4: log2 zoom factor per pass; legal range 1..NB.
REQ-004 Parameter SW = $clog2(NP+1): width of shift fields.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a measurement.
REQ-008 win_valid  output  1  window descriptor valid.
REQ-009 win_ready  input  1  histogrammer accepts window.
REQ-010 win_base  output  NP  window lower bound (TDC code).
REQ-011 win_hi  output  NP  window upper bound, inclusive.
REQ-012 win_shift  output  SW  log2 bin width s for this pass.
REQ-013 peak_valid  input  1  histogram peak result valid, one-cycle pulse.
REQ-014 peak_bin  input  NB  index of peak bin.
REQ-015 peak_none  input  1  histogram empty; qualified by peak_valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 res_valid  output  1  one-cycle result pulse.
REQ-018 res_tof  output  NP  final time-of-flight code.
REQ-019 res_err  output  1  measurement aborted (no peak); qualified by res_valid.
REQ-020 res_passes  output  SW  number of histogram passes performed.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT, CALC, DONE.
REQ-022 IDLE: start=1 -> load base B=0, s=NP-NB, pass count=0 -> ISSUE; start in any other state SHALL be ignored.
REQ-023 ISSUE: win_valid=1 with win_base=B, win_shift=s, win_hi=B+2^(s+NB)-1; win_base/win_hi/win_shift SHALL be held stable until win_ready=1; on win_valid&win_ready -> WAIT, pass count +1.
REQ-024 WAIT: peak_valid=1 -> capture peak_bin/peak_none -> CALC; peak_valid outside WAIT SHALL be ignored.
REQ-025 CALC (one cycle): if peak_none -> DONE with err=1, tof=0.
REQ-026 CALC, s=0: tof=B+peak_bin -> DONE, err=0.
REQ-027 CALC, s>0: center C=B+(peak_bin<<s)+2^(s-1); s'=max(s-ZS,0); half=2^(s'+NB-1); B'=C-half, computed at NP+1 bits signed.
REQ-028 Clamp: B'<0 -> B'=0; B'>2^NP-2^(s'+NB) -> B'=2^NP-2^(s'+NB); then -> ISSUE with B=B', s=s'.
REQ-029 DONE: res_valid=1 for exactly one cycle with res_tof, res_err, res_passes; -> IDLE next cycle.
REQ-030 res_tof/res_err/res_passes SHALL hold their values until the next DONE.
REQ-031 Latency: start at cycle t -> win_valid at t+1; peak_valid at t -> next win_valid or res_valid at t+2.
REQ-032 win_valid SHALL be 0 outside ISSUE; busy SHALL be 1 in the cycle res_valid is asserted.
REQ-033 Successful pass count SHALL equal ceil((NP-NB)/ZS)+1.

Reset
REQ-034 rst_n=0 SHALL force IDLE immediately, mid-operation included, with all outputs 0.
REQ-035 After rst_n release, no win_valid or res_valid SHALL occur before a new start.

Verification (NP=16, NB=4)
REQ-036 ZS=4; start; peaks 5,15,3,9 -> windows (base,shift) (0,12),(20480,8),(24320,4),(24368,0); res_tof=24377, res_passes=4, res_err=0.
REQ-037 ZS=2; first peak 0 -> second window base 0, shift 10; rerun with first peak 15 -> second window base 49152, win_hi 65535.
REQ-038 ZS=4; win_ready held low 5 cycles in pass 2 -> win_base/win_hi/win_shift stable throughout; result unchanged.
REQ-039 Pass 2 peak_valid with peak_none=1 -> res_valid with res_err=1, res_tof=0, res_passes=2.
REQ-040 rst_n low during WAIT of pass 3, then start -> fresh run begins at base 0, shift 12; stray peak_valid and start while busy ignored.
